// File: rtl/seq_ring_pkg.sv
// Shared types and helpers for the one-hot ring sequence checker.
//   BITS_COUNT    : ring width (one-hot) used throughout the slice
//   ring_state_t  : HUNT / SYNC / LOCKED tracking states
//   rotl1()       : next ring value (rotate left by one, MSB wraps to bit 0)
//   is_onehot()   : exactly one bit set
package seq_ring_pkg;

  localparam int BITS_COUNT = 4;

  typedef logic [BITS_COUNT-1:0] ring_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } ring_state_t;

  function automatic ring_t rotl1(input ring_t v);
    return {v[BITS_COUNT-2:0], v[BITS_COUNT-1]};
  endfunction

  // v & (v - 1) clears the lowest set bit; zero afterwards means at most one
  // bit was set, and the v != 0 term rules out the empty value.
  function automatic logic is_onehot(input ring_t v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seq_ring_checker_if.sv
// Sample/status bundle between the counter-side driver and the checker.
//   master : drives valid_in, load_seen, count_in; observes status
//   slave  : the checker; receives samples, drives locked, err_pulse,
//            err_count, lap_count, idx_out, idx_valid
interface seq_ring_checker_if #(
  parameter int BITS_COUNT = seq_ring_pkg::BITS_COUNT,
  parameter int ERR_W      = 8,
  parameter int LAP_W      = 8
);
  localparam int IDX_W = $clog2(BITS_COUNT);

  logic                  valid_in;
  logic                  load_seen;
  logic [BITS_COUNT-1:0] count_in;
  logic                  locked;
  logic                  err_pulse;
  logic [ERR_W-1:0]      err_count;
  logic [LAP_W-1:0]      lap_count;
  logic [IDX_W-1:0]      idx_out;
  logic                  idx_valid;

  modport master (
    output valid_in, load_seen, count_in,
    input  locked, err_pulse, err_count, lap_count, idx_out, idx_valid
  );

  modport slave (
    input  valid_in, load_seen, count_in,
    output locked, err_pulse, err_count, lap_count, idx_out, idx_valid
  );
endinterface

// File: rtl/seq_ring_checker_onehot_to_bin.sv
// Combinational one-hot decoder.
//   onehot : ring sample
//   idx    : binary position of the set bit (meaningful only when legal=1)
//   legal  : exactly one bit of onehot is set
module onehot_to_bin
  import seq_ring_pkg::*;
#(
  parameter int BITS_COUNT = seq_ring_pkg::BITS_COUNT,
  parameter int IDX_W      = $clog2(BITS_COUNT)
) (
  input  logic [BITS_COUNT-1:0] onehot,
  output logic [IDX_W-1:0]      idx,
  output logic                  legal
);

  assign legal = is_onehot(onehot);

  // OR of the positions of all set bits; exact for legal inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    idx = '0;
    for (int i = 0; i < BITS_COUNT; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/seq_ring_checker.sv
// Receive-side monitor for the one-hot ring 1->2->4->8->1.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : slave side of seq_ring_checker_if (samples in, status out)
// The ring helpers in seq_ring_pkg are sized to the package ring width, so
// BITS_COUNT overrides must agree with seq_ring_pkg::BITS_COUNT.
module seq_ring_checker
  import seq_ring_pkg::*;
#(
  parameter int BITS_COUNT = seq_ring_pkg::BITS_COUNT,
  parameter int LOCK_N     = 2,
  parameter int UNLOCK_N   = 3,
  parameter int ERR_W      = 8,
  parameter int LAP_W      = 8
) (
  input logic              clk,
  input logic              reset,
  seq_ring_checker_if.slave bus
);

  localparam int IDX_W   = $clog2(BITS_COUNT);
  localparam int CNT_MAX = (LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ring_state_t           state_q, state_n;
  logic [BITS_COUNT-1:0] expected_q, expected_n;
  logic [CNT_W-1:0]      match_q, match_n, match_inc;
  logic [CNT_W-1:0]      miss_q, miss_n, miss_inc;
  logic                  err_pulse_q, err_pulse_n;
  logic [ERR_W-1:0]      err_count_q, err_count_n;
  logic [LAP_W-1:0]      lap_count_q, lap_count_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic                  idx_valid_q, idx_valid_n;

  logic [IDX_W-1:0]      dec_idx;
  logic                  legal;

  onehot_to_bin #(.BITS_COUNT(BITS_COUNT), .IDX_W(IDX_W)) u_dec (
    .onehot (bus.count_in),
    .idx    (dec_idx),
    .legal  (legal)
  );

  assign match_inc = match_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;

  always_comb begin
    state_n     = state_q;
    expected_n  = expected_q;
    match_n     = match_q;
    miss_n      = miss_q;
    err_pulse_n = 1'b0;
    err_count_n = err_count_q;
    lap_count_n = lap_count_q;
    idx_n       = idx_q;
    idx_valid_n = idx_valid_q;

    if (bus.valid_in) begin
      idx_valid_n = legal;
      if (legal) idx_n = dec_idx;

      // A legal sample that starts (or restarts) tracking: used by load_seen,
      // HUNT, and SYNC mispredictions alike.
      if (bus.load_seen || state_q == HUNT ||
          (state_q == SYNC && bus.count_in != expected_q)) begin
        if (legal) begin
          expected_n = rotl1(bus.count_in);
          match_n    = CNT_W'(1);
          miss_n     = '0;
          state_n    = (LOCK_N == 1) ? LOCKED : SYNC;
        end else begin
          state_n    = HUNT;
        end
      end else if (state_q == SYNC) begin
        expected_n = rotl1(expected_q);
        match_n    = match_inc;
        if (match_inc >= CNT_W'(LOCK_N)) begin
          state_n = LOCKED;
          miss_n  = '0;
        end
      end else if (state_q == LOCKED) begin
        // Flywheel: the prediction advances on every sample, hit or miss.
        expected_n = rotl1(expected_q);
        if (bus.count_in == expected_q) begin
          miss_n = '0;
          if (bus.count_in == BITS_COUNT'(1)) lap_count_n = lap_count_q + 1'b1;
        end else begin
          err_pulse_n = 1'b1;
          if (err_count_q != '1) err_count_n = err_count_q + 1'b1;
          miss_n = miss_inc;
          if (miss_inc >= CNT_W'(UNLOCK_N)) state_n = HUNT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      lap_count_q <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_n;
      expected_q  <= expected_n;
      match_q     <= match_n;
      miss_q      <= miss_n;
      err_pulse_q <= err_pulse_n;
      err_count_q <= err_count_n;
      lap_count_q <= lap_count_n;
      idx_q       <= idx_n;
      idx_valid_q <= idx_valid_n;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.lap_count = lap_count_q;
  assign bus.idx_out   = idx_q;
  assign bus.idx_valid = idx_valid_q;

endmodule

// File: tb/tb_seq_ring_checker.sv
// Directed bench for seq_ring_checker. dut1 uses default parameters;
// dut2 (ERR_W=2, UNLOCK_N=8) covers error saturation and lap wrap.
module tb_seq_ring_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_ring_checker_if #(.BITS_COUNT(4), .ERR_W(8), .LAP_W(8)) b1 ();
  seq_ring_checker_if #(.BITS_COUNT(4), .ERR_W(2), .LAP_W(8)) b2 ();

  seq_ring_checker #(.BITS_COUNT(4), .LOCK_N(2), .UNLOCK_N(3), .ERR_W(8), .LAP_W(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  seq_ring_checker #(.BITS_COUNT(4), .LOCK_N(2), .UNLOCK_N(8), .ERR_W(2), .LAP_W(8)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample on the falling edge, then look 1 time unit after the
  // rising edge that captures it.
  task automatic s1(input logic [3:0] v, input logic ld = 1'b0, input logic vld = 1'b1);
    @(negedge clk);
    b1.valid_in = vld; b1.load_seen = ld; b1.count_in = v;
    @(posedge clk); #1;
    b1.valid_in = 1'b0; b1.load_seen = 1'b0;
  endtask

  task automatic s2(input logic [3:0] v);
    @(negedge clk);
    b2.valid_in = 1'b1; b2.load_seen = 1'b0; b2.count_in = v;
    @(posedge clk); #1;
    b2.valid_in = 1'b0;
  endtask

  initial begin
    b1.valid_in = 1'b0; b1.load_seen = 1'b0; b1.count_in = '0;
    b2.valid_in = 1'b0; b2.load_seen = 1'b0; b2.count_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    check("rst_locked",    b1.locked,    0);
    check("rst_err_pulse", b1.err_pulse, 0);
    check("rst_err_count", b1.err_count, 0);
    check("rst_lap_count", b1.lap_count, 0);
    check("rst_idx_out",   b1.idx_out,   0);
    check("rst_idx_valid", b1.idx_valid, 0);

    // 1. Acquire lock on 1,2,4,8,1,2.
    s1(4'd1); check("t1_s1_locked", b1.locked, 0); check("t1_s1_idx", b1.idx_out, 0);
    check("t1_s1_idxv", b1.idx_valid, 1);
    s1(4'd2); check("t1_s2_locked", b1.locked, 1);
    s1(4'd4); check("t1_s3_idx", b1.idx_out, 2);
    s1(4'd8); check("t1_s4_lap", b1.lap_count, 0); check("t1_s4_idx", b1.idx_out, 3);
    s1(4'd1); check("t1_s5_lap", b1.lap_count, 1);
    s1(4'd2); check("t1_s6_err", b1.err_count, 0); check("t1_s6_locked", b1.locked, 1);

    // 2. Continue the ring (4,8), then 1,2,0,8: one error, flywheel recovers.
    s1(4'd4); s1(4'd8);
    s1(4'd1); check("t2_lap", b1.lap_count, 2);
    s1(4'd2); check("t2_pre_pulse", b1.err_pulse, 0);
    s1(4'd0);
    check("t2_zero_pulse",  b1.err_pulse, 1);
    check("t2_zero_errcnt", b1.err_count, 1);
    check("t2_zero_locked", b1.locked,    1);
    check("t2_zero_idxv",   b1.idx_valid, 0);
    check("t2_zero_idx",    b1.idx_out,   1);
    s1(4'd8);
    check("t2_fly_pulse",  b1.err_pulse, 0);
    check("t2_fly_errcnt", b1.err_count, 1);
    check("t2_fly_idxv",   b1.idx_valid, 1);
    check("t2_fly_idx",    b1.idx_out,   3);

    // 3. Three multi-hot misses drop lock; 4,8 relock; 1 counts a lap.
    s1(4'd3); check("t3_m1_pulse", b1.err_pulse, 1); check("t3_m1_locked", b1.locked, 1);
    check("t3_m1_idxv", b1.idx_valid, 0);
    s1(4'd3); check("t3_m2_err", b1.err_count, 3); check("t3_m2_locked", b1.locked, 1);
    s1(4'd3); check("t3_m3_pulse", b1.err_pulse, 1); check("t3_m3_err", b1.err_count, 4);
    check("t3_m3_locked", b1.locked, 0);
    s1(4'd4); check("t3_sync_locked", b1.locked, 0); check("t3_sync_pulse", b1.err_pulse, 0);
    s1(4'd8); check("t3_relock", b1.locked, 1);
    s1(4'd1); check("t3_lap", b1.lap_count, 3);

    // 4. Locked expecting 2; load_seen with 8 resyncs without error.
    s1(4'd2);
    s1(4'd8, 1'b1);
    check("t4_load_pulse",  b1.err_pulse, 0);
    check("t4_load_locked", b1.locked,    0);
    check("t4_load_err",    b1.err_count, 4);
    check("t4_load_idx",    b1.idx_out,   3);
    s1(4'd1);
    check("t4_relock",    b1.locked,    1);
    check("t4_sync_pulse", b1.err_pulse, 0);
    check("t4_sync_lap",  b1.lap_count, 3);
    s1(4'd2); s1(4'd4); s1(4'd8); s1(4'd1);
    check("t4_lap", b1.lap_count, 4);

    // 5. valid_in low with garbage on count_in: nothing moves.
    s1(4'd5, 1'b0, 1'b0); check("t5_i1_pulse", b1.err_pulse, 0);
    s1(4'd0, 1'b1, 1'b0); check("t5_i2_pulse", b1.err_pulse, 0);
    s1(4'd15, 1'b0, 1'b0); check("t5_i3_pulse", b1.err_pulse, 0);
    s1(4'd3, 1'b0, 1'b0); check("t5_i4_pulse", b1.err_pulse, 0);
    s1(4'd6, 1'b0, 1'b0);
    check("t5_hold_pulse",  b1.err_pulse, 0);
    check("t5_hold_locked", b1.locked,    1);
    check("t5_hold_err",    b1.err_count, 4);
    check("t5_hold_lap",    b1.lap_count, 4);
    check("t5_hold_idx",    b1.idx_out,   0);
    check("t5_hold_idxv",   b1.idx_valid, 1);
    s1(4'd2); check("t5_resume_pulse", b1.err_pulse, 0);

    // Asynchronous reset between edges.
    @(posedge clk); #2 reset = 1'b1; #1;
    check("t5_arst_locked", b1.locked,    0);
    check("t5_arst_err",    b1.err_count, 0);
    check("t5_arst_lap",    b1.lap_count, 0);
    check("t5_arst_idx",    b1.idx_out,   0);
    check("t5_arst_idxv",   b1.idx_valid, 0);
    check("t5_arst_pulse",  b1.err_pulse, 0);
    @(negedge clk) reset = 1'b0;

    // 6. dut2: saturation at 3, then 256 laps wrap lap_count to 0.
    s2(4'd1); s2(4'd2); check("t6_locked", b2.locked, 1);
    s2(4'd0); check("t6_e1", b2.err_count, 1);
    s2(4'd0); check("t6_e2", b2.err_count, 2);
    s2(4'd0); check("t6_e3", b2.err_count, 3);
    s2(4'd0); check("t6_e4", b2.err_count, 3);
    s2(4'd0); check("t6_e5", b2.err_count, 3); check("t6_e5_pulse", b2.err_pulse, 1);
    check("t6_still_locked", b2.locked, 1);
    s2(4'd8); check("t6_fly_pulse", b2.err_pulse, 0);
    for (int lap = 0; lap < 255; lap++) begin
      s2(4'd1); s2(4'd2); s2(4'd4); s2(4'd8);
    end
    check("t6_lap255", b2.lap_count, 255);
    s2(4'd1); check("t6_lap_wrap", b2.lap_count, 0);
    check("t6_final_err", b2.err_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
